// File: rtl/q3a_window_gen.sv
// ---------------------------------------------------------------------------
// q3a_window_gen
//   Stimulus transmitter for the Q3a 2-of-3 window monitor. Requested window
//   results are queued in a small flag FIFO. On a start request the block
//   arms the monitor with a one-cycle s pulse. It then drives w as
//   back-to-back 3-cycle windows. A 1-flag window carries exactly two ones.
//   A 0-flag window carries a count of ones other than two. The block also
//   reports the z value the monitor must produce for each finished window.
//
// Ports
//   clk           single clock, all logic on posedge
//   reset         synchronous, active-high
//   en            start request, sampled only while idle
//   flag_valid    flag push request
//   flag_data     requested window result
//   flag_ready    push accepted when flag_valid && flag_ready (= not full)
//   s             monitor arm pulse
//   w             monitor data bit
//   phase         window position 0..2 (0 outside streaming)
//   exp_z         z the monitor must show this cycle
//   exp_valid     exp_z is meaningful this cycle
//   fifo_count    entries held in the flag FIFO
//   underrun_cnt  windows filled without a queued flag (saturating)
// ---------------------------------------------------------------------------
module q3a_window_gen #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          flag_valid,
   input  logic                          flag_data,
   output logic                          flag_ready,
   output logic                          s,
   output logic                          w,
   output logic [1:0]                    phase,
   output logic                          exp_z,
   output logic                          exp_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              underrun_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   state_t               r_state;
   logic [FIFO_DEPTH-1:0] r_mem;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 r_s;
   logic                 r_w;
   logic [1:0]           r_phase;
   logic                 r_exp_z;
   logic                 r_exp_valid;
   logic [CNT_W-1:0]     r_underrun;
   logic                 r_flag;      // flag of the window being driven
   logic [2:0]           r_pat;       // pattern of that window, bit 2 first
   logic [1:0]           r_pos_ptr;   // rotation index for 1-windows (0..2)
   logic [2:0]           r_neg_ptr;   // rotation index for 0-windows (0..4)

   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_load;
   logic                 w_pop;
   logic                 w_load_flag;
   logic [2:0]           w_load_pat;

   // Two-ones patterns for a 1-window
   function automatic logic [2:0] pos_pat(input logic [1:0] ptr);
      case (ptr)
         2'd0:    return 3'b110;
         2'd1:    return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   // Patterns with zero, one or three ones for a 0-window
   function automatic logic [2:0] neg_pat(input logic [2:0] ptr);
      case (ptr)
         3'd0:    return 3'b000;
         3'd1:    return 3'b100;
         3'd2:    return 3'b010;
         3'd3:    return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = flag_valid && !w_full;
   // A new window is loaded on the edge that enters its phase-0 cycle
   assign w_load      = (r_state == ST_START) ||
                        ((r_state == ST_STREAM) && (r_phase == 2'd2));
   assign w_pop       = w_load && !w_empty;
   assign w_load_flag = w_empty ? 1'b0 : r_mem[r_rd_ptr];
   assign w_load_pat  = w_load_flag ? pos_pat(r_pos_ptr) : neg_pat(r_neg_ptr);

   // Control state, FIFO bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_s         <= 1'b0;
         r_w         <= 1'b0;
         r_phase     <= 2'd0;
         r_exp_z     <= 1'b0;
         r_exp_valid <= 1'b0;
         r_underrun  <= '0;
         r_pos_ptr   <= 2'd0;
         r_neg_ptr   <= 3'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase

         if (w_load) begin
            r_phase <= 2'd0;
            r_w     <= w_load_pat[2];
            if (w_load_flag)
               r_pos_ptr <= (r_pos_ptr == 2'd2) ? 2'd0 : r_pos_ptr + 2'd1;
            else
               r_neg_ptr <= (r_neg_ptr == 3'd4) ? 3'd0 : r_neg_ptr + 3'd1;
            if (w_empty) r_underrun <= sat_inc(r_underrun);
         end

         case (r_state)
            ST_IDLE: begin
               r_s         <= en;
               r_w         <= 1'b0;
               r_phase     <= 2'd0;
               r_exp_z     <= 1'b0;
               r_exp_valid <= 1'b0;
               if (en) r_state <= ST_START;
            end
            ST_START: begin
               // First phase 0 has no finished window to report
               r_s         <= 1'b0;
               r_exp_z     <= 1'b0;
               r_exp_valid <= 1'b0;
               r_state     <= ST_STREAM;
            end
            ST_STREAM: begin
               r_s <= 1'b0;
               if (r_phase == 2'd2) begin
                  // Monitor registers z, so the result lands in the next phase 0
                  r_exp_z     <= r_flag;
                  r_exp_valid <= 1'b1;
               end else begin
                  r_phase     <= r_phase + 2'd1;
                  r_w         <= (r_phase == 2'd0) ? r_pat[1] : r_pat[0];
                  r_exp_z     <= 1'b0;
                  r_exp_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // FIFO storage and current-window data (no reset needed)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= flag_data;
      if (w_load) begin
         r_flag <= w_load_flag;
         r_pat  <= w_load_pat;
      end
   end

   assign flag_ready   = !w_full;
   assign s            = r_s;
   assign w            = r_w;
   assign phase        = r_phase;
   assign exp_z        = r_exp_z;
   assign exp_valid    = r_exp_valid;
   assign fifo_count   = r_count;
   assign underrun_cnt = r_underrun;

endmodule
